// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared definitions for the execute stage: ALU control codes,
//                forward-select codes and the packed ID/EX register layout.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

   // The ID/EX record is sized here, so these must track the XLEN/REGW
   // parameters of ex_stage.
   localparam int EX_XLEN = 32;
   localparam int EX_REGW = 5;

   // ALU control codes produced by the ALU decoder
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Forward selects from the hazard unit; 2'b11 is reserved and reads the
   // register-file value.
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // All-zero value of this record is a bubble: no write, no memory access,
   // no redirect, ALU op add.
   typedef struct packed {
      logic                 regwrite;
      logic [1:0]           resultsrc;
      logic                 memwrite;
      logic                 jump;
      logic                 branch;
      logic                 alusrc;
      logic [2:0]           alucontrol;
      logic [EX_XLEN-1:0]   rd1;
      logic [EX_XLEN-1:0]   rd2;
      logic [EX_XLEN-1:0]   pc;
      logic [EX_XLEN-1:0]   immext;
      logic [EX_XLEN-1:0]   pcplus4;
      logic [EX_REGW-1:0]   rs1;
      logic [EX_REGW-1:0]   rs2;
      logic [EX_REGW-1:0]   rd;
   } id_ex_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational RV32I execute ALU (add/sub/and/or/xor/slt).
//  Ports       : a, b        - operands
//                ALUControl  - 3-bit op code (see ex_pkg)
//                result      - ALU result; codes 110/111 give 0
//                zero        - result == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      ALUControl,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   logic w_lt;

   assign w_lt = ($signed(a) < $signed(b));

   always_comb begin
      result = '0;
      case (ALUControl)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLT: result = {{(XLEN-1){1'b0}}, w_lt};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage of the 5-stage RV32I pipeline. Holds the ID/EX
//                register, forwards operands, runs the ALU and resolves
//                branches and jumps.
//  Ports       : clk, rst            - clock / async active-high reset
//                StallE, FlushE      - ID/EX hold / bubble (flush wins)
//                *D                  - decode-stage control, data and indices
//                ForwardAE/BE        - forwarding selects from hazard unit
//                ALUResultM, ResultW - forwarding sources
//                RegWriteE, ResultSrcE, MemWriteE, Rs1E, Rs2E, RdE, PCPlus4E
//                                    - registered copies
//                ALUResultE, WriteDataE, PCTargetE, PCSrcE
//                                    - combinational execute results
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallE,
   input  logic            FlushE,
   input  logic            RegWriteD,
   input  logic [1:0]      ResultSrcD,
   input  logic            MemWriteD,
   input  logic            JumpD,
   input  logic            BranchD,
   input  logic            ALUSrcD,
   input  logic [2:0]      ALUControlD,
   input  logic [XLEN-1:0] RD1D,
   input  logic [XLEN-1:0] RD2D,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] ImmExtD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic [REGW-1:0] Rs1D,
   input  logic [REGW-1:0] Rs2D,
   input  logic [REGW-1:0] RdD,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] ResultW,
   output logic            RegWriteE,
   output logic [1:0]      ResultSrcE,
   output logic            MemWriteE,
   output logic [REGW-1:0] Rs1E,
   output logic [REGW-1:0] Rs2E,
   output logic [REGW-1:0] RdE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [XLEN-1:0] ALUResultE,
   output logic [XLEN-1:0] WriteDataE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            PCSrcE
);

   id_ex_t          r_idex;
   id_ex_t          w_idex_d;
   logic [XLEN-1:0] w_srca;
   logic [XLEN-1:0] w_srcb;
   logic            w_zero;

   always_comb begin
      w_idex_d            = '0;
      w_idex_d.regwrite   = RegWriteD;
      w_idex_d.resultsrc  = ResultSrcD;
      w_idex_d.memwrite   = MemWriteD;
      w_idex_d.jump       = JumpD;
      w_idex_d.branch     = BranchD;
      w_idex_d.alusrc     = ALUSrcD;
      w_idex_d.alucontrol = ALUControlD;
      w_idex_d.rd1        = RD1D;
      w_idex_d.rd2        = RD2D;
      w_idex_d.pc         = PCD;
      w_idex_d.immext     = ImmExtD;
      w_idex_d.pcplus4    = PCPlus4D;
      w_idex_d.rs1        = Rs1D;
      w_idex_d.rs2        = Rs2D;
      w_idex_d.rd         = RdD;
   end

   // Flush is tested before stall so a simultaneous flush+stall still
   // inserts a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_idex <= '0;
      else if (FlushE)
         r_idex <= '0;
      else if (!StallE)
         r_idex <= w_idex_d;
   end

   // Operand forwarding; the reserved select 11 falls back to the RF value.
   always_comb begin
      w_srca = r_idex.rd1;
      case (ForwardAE)
         FWD_W:   w_srca = ResultW;
         FWD_M:   w_srca = ALUResultM;
         default: w_srca = r_idex.rd1;
      endcase
   end

   always_comb begin
      WriteDataE = r_idex.rd2;
      case (ForwardBE)
         FWD_W:   WriteDataE = ResultW;
         FWD_M:   WriteDataE = ALUResultM;
         default: WriteDataE = r_idex.rd2;
      endcase
   end

   assign w_srcb = r_idex.alusrc ? r_idex.immext : WriteDataE;

   alu #(
      .XLEN (XLEN)
   ) u_alu (
      .a          (w_srca),
      .b          (w_srcb),
      .ALUControl (r_idex.alucontrol),
      .result     (ALUResultE),
      .zero       (w_zero)
   );

   assign PCTargetE  = r_idex.pc + r_idex.immext;
   assign PCSrcE     = (r_idex.branch & w_zero) | r_idex.jump;

   assign RegWriteE  = r_idex.regwrite;
   assign ResultSrcE = r_idex.resultsrc;
   assign MemWriteE  = r_idex.memwrite;
   assign Rs1E       = r_idex.rs1;
   assign Rs2E       = r_idex.rs2;
   assign RdE        = r_idex.rd;
   assign PCPlus4E   = r_idex.pcplus4;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Self-checking bench for ex_stage. A reference model of the
//                ID/EX register predicts the E-stage outputs for every clock
//                edge; predictions are queued and compared after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ex_stage;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            StallE, FlushE;
   logic            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
   logic [1:0]      ResultSrcD;
   logic [2:0]      ALUControlD;
   logic [XLEN-1:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
   logic [REGW-1:0] Rs1D, Rs2D, RdD;
   logic [1:0]      ForwardAE, ForwardBE;
   logic [XLEN-1:0] ALUResultM, ResultW;
   logic            RegWriteE, MemWriteE, PCSrcE;
   logic [1:0]      ResultSrcE;
   logic [REGW-1:0] Rs1E, Rs2E, RdE;
   logic [XLEN-1:0] PCPlus4E, ALUResultE, WriteDataE, PCTargetE;

   always #5 clk = ~clk;

   ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
      .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
      .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
      .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
      .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
      .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
      .RdD(RdD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ALUResultM(ALUResultM), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCPlus4E(PCPlus4E),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
      .PCTargetE(PCTargetE), .PCSrcE(PCSrcE)
   );

   typedef struct packed {
      logic        rw;
      logic [1:0]  rs;
      logic        mw, j, b, asrc;
      logic [2:0]  ac;
      logic [31:0] rd1, rd2, pc, imm, pcp4;
      logic [4:0]  rs1, rs2, rd;
   } mreg_t;

   typedef struct packed {
      logic        rw;
      logic [1:0]  rs;
      logic        mw;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] pcp4, alu, wd, tgt;
      logic        pcsrc;
   } exp_t;

   mreg_t m_e;
   exp_t  sb_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
         default: return 32'd0;
      endcase
   endfunction

   function automatic exp_t predict();
      exp_t        e;
      logic [31:0] sa, wd, sb;
      sa = (ForwardAE == 2'b01) ? ResultW : (ForwardAE == 2'b10) ? ALUResultM : m_e.rd1;
      wd = (ForwardBE == 2'b01) ? ResultW : (ForwardBE == 2'b10) ? ALUResultM : m_e.rd2;
      sb = m_e.asrc ? m_e.imm : wd;
      e.rw    = m_e.rw;
      e.rs    = m_e.rs;
      e.mw    = m_e.mw;
      e.rs1   = m_e.rs1;
      e.rs2   = m_e.rs2;
      e.rd    = m_e.rd;
      e.pcp4  = m_e.pcp4;
      e.alu   = model_alu(m_e.ac, sa, sb);
      e.wd    = wd;
      e.tgt   = m_e.pc + m_e.imm;
      e.pcsrc = (m_e.b && (e.alu == 32'd0)) || m_e.j;
      return e;
   endfunction

   task automatic compare(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "/alu"},   ALUResultE, e.alu);
         chk({tag, "/wd"},    WriteDataE, e.wd);
         chk({tag, "/tgt"},   PCTargetE,  e.tgt);
         chk({tag, "/pcsrc"}, {31'd0, PCSrcE},    {31'd0, e.pcsrc});
         chk({tag, "/rw"},    {31'd0, RegWriteE}, {31'd0, e.rw});
         chk({tag, "/mw"},    {31'd0, MemWriteE}, {31'd0, e.mw});
         chk({tag, "/rs"},    {30'd0, ResultSrcE}, {30'd0, e.rs});
         chk({tag, "/idx"},   {17'd0, Rs1E, Rs2E, RdE}, {17'd0, e.rs1, e.rs2, e.rd});
         chk({tag, "/pcp4"},  PCPlus4E,   e.pcp4);
      end
   endtask

   // Advance the model register exactly as the stage should, queue the
   // prediction, then take one edge and compare.
   task automatic step(input string tag);
      if (FlushE) begin
         m_e = '0;
      end else if (!StallE) begin
         m_e.rw = RegWriteD;   m_e.rs = ResultSrcD;  m_e.mw = MemWriteD;
         m_e.j  = JumpD;       m_e.b  = BranchD;     m_e.asrc = ALUSrcD;
         m_e.ac = ALUControlD; m_e.rd1 = RD1D;       m_e.rd2 = RD2D;
         m_e.pc = PCD;         m_e.imm = ImmExtD;    m_e.pcp4 = PCPlus4D;
         m_e.rs1 = Rs1D;       m_e.rs2 = Rs2D;       m_e.rd = RdD;
      end
      sb_q.push_back(predict());
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   task automatic check_zeroed(input string tag);
      chk({tag, "/rw"},    {31'd0, RegWriteE}, 32'd0);
      chk({tag, "/mw"},    {31'd0, MemWriteE}, 32'd0);
      chk({tag, "/rs"},    {30'd0, ResultSrcE}, 32'd0);
      chk({tag, "/pcsrc"}, {31'd0, PCSrcE},    32'd0);
      chk({tag, "/rd"},    {27'd0, RdE},       32'd0);
      chk({tag, "/alu"},   ALUResultE,         32'd0);
      chk({tag, "/tgt"},   PCTargetE,          32'd0);
   endtask

   initial begin
      rst = 1'b1; StallE = 0; FlushE = 0;
      RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0;
      ALUSrcD = 0; ALUControlD = 0; RD1D = 0; RD2D = 0; PCD = 0; ImmExtD = 0;
      PCPlus4D = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
      ForwardAE = 0; ForwardBE = 0; ALUResultM = 0; ResultW = 0;
      m_e = '0;

      @(negedge clk);
      check_zeroed("reset");
      rst = 1'b0;

      // sub 7-5
      RegWriteD = 1; ResultSrcD = 2'b01; RdD = 5'd3; Rs1D = 5'd1; Rs2D = 5'd2;
      RD1D = 32'd7; RD2D = 32'd5; ALUControlD = 3'b001; PCPlus4D = 32'h14;
      step("sub");
      // signed slt: -1 < 5
      RD1D = 32'hFFFF_FFFF; ALUControlD = 3'b101; MemWriteD = 1;
      step("slt");
      // slt false: 5 < -1 is false
      RD1D = 32'd5; RD2D = 32'hFFFF_FFFF; MemWriteD = 0;
      step("slt0");

      // forwarding M into A, W into B
      ALUResultM = 32'h100; ResultW = 32'h200; ForwardAE = 2'b10; ForwardBE = 2'b01;
      RD1D = 32'h11; RD2D = 32'h22; ALUControlD = 3'b000; RdD = 5'd4;
      step("fwd");
      // reserved select reads RF; immediate operand on B
      ForwardAE = 2'b11; ForwardBE = 2'b10; ALUSrcD = 1; ImmExtD = 32'h40;
      step("fwdres");
      ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcD = 0;

      // logic ops with random operands
      for (int k = 0; k < 3; k++) begin
         ALUControlD = 3'(3'b010 + k);
         RD1D = $urandom; RD2D = $urandom; Rs1D = 5'($urandom_range(31));
         step("logic");
      end

      // branch taken / not taken
      BranchD = 1; RegWriteD = 0; RD1D = 32'd9; RD2D = 32'd9; ALUControlD = 3'b001;
      PCD = 32'h40; ImmExtD = 32'hFFFF_FFF8;
      step("beq_t");
      RD2D = 32'd8;
      step("beq_nt");
      BranchD = 0; JumpD = 1;
      step("jal");
      JumpD = 0;

      // flush wins over stall, then stall holds the bubble
      RegWriteD = 1; RdD = 5'd3;
      step("load3");
      FlushE = 1; StallE = 1;
      step("flushstall");
      FlushE = 0; RdD = 5'd9; JumpD = 1; RD1D = 32'h55;
      step("stallbubble");
      JumpD = 0;

      // load then hold for three edges with changing inputs
      StallE = 0; RdD = 5'd12; RD1D = 32'h1234; RD2D = 32'h34; ALUControlD = 3'b000;
      step("preload");
      StallE = 1;
      for (int k = 0; k < 3; k++) begin
         RdD = 5'(k + 20); RD1D = $urandom; ALUControlD = 3'(k); RegWriteD = k[0];
         step("hold");
      end
      StallE = 0;

      // reserved ALU code gives 0, so a branch is taken
      ALUControlD = 3'b110; RD1D = 32'd5; RD2D = 32'd3; BranchD = 1; PCD = 32'h100;
      ImmExtD = 32'h20;
      step("rsvd110");
      ALUControlD = 3'b111; BranchD = 0;
      step("rsvd111");

      // asynchronous reset between edges with RegWriteE=1 and a redirect
      RegWriteD = 1; RdD = 5'd7; JumpD = 1;
      step("prerst");
      #2 rst = 1'b1;
      #1 check_zeroed("asyncrst");
      #1 rst = 1'b0;
      m_e = '0;
      JumpD = 0; RegWriteD = 0;
      step("postrst");

      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d leftover entries expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline.
- Captures decode-stage control and operands in the ID/EX pipeline register, including the 3-bit ALU control code from the ALU decoder.
- Applies forwarding, runs the ALU and resolves branches/jumps.
- Drives the EX/MEM register inputs and the fetch-redirect signals.

Parameters:
- XLEN, 32, datapath and PC width.
- REGW, 5, register-index width.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: asynchronous active-high reset.
- StallE in 1: hold the ID/EX register.
- FlushE in 1: load a bubble into the ID/EX register.
- RegWriteD in 1: decode control.
- ResultSrcD in 2: decode control.
- MemWriteD in 1: decode control.
- JumpD in 1: decode control.
- BranchD in 1: decode control.
- ALUSrcD in 1: decode control, 1 selects the immediate.
- ALUControlD in 3: ALU op from the ALU decoder.
- RD1D in XLEN: register-file read data 1.
- RD2D in XLEN: register-file read data 2.
- PCD in XLEN: decode PC.
- ImmExtD in XLEN: extended immediate.
- PCPlus4D in XLEN: decode PC+4.
- Rs1D in REGW: source register 1 index.
- Rs2D in REGW: source register 2 index.
- RdD in REGW: destination register index.
- ForwardAE in 2: forwarding select for SrcA, from the hazard unit.
- ForwardBE in 2: forwarding select for SrcB, from the hazard unit.
- ALUResultM in XLEN: memory-stage result for forwarding.
- ResultW in XLEN: writeback result for forwarding.
- RegWriteE out 1: registered control.
- ResultSrcE out 2: registered control.
- MemWriteE out 1: registered control.
- Rs1E out REGW: registered index, to the hazard unit.
- Rs2E out REGW: registered index, to the hazard unit.
- RdE out REGW: registered index, to the hazard unit and EX/MEM.
- PCPlus4E out XLEN: registered.
- ALUResultE out XLEN: combinational.
- WriteDataE out XLEN: forwarded RD2.
- PCTargetE out XLEN: PCE + ImmExtE.
- PCSrcE out 1: redirect fetch.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high. Asserting rst clears every ID/EX register field to 0 immediately, without waiting for clk.
- Reset values: with all E-stage registers 0, RegWriteE=0, MemWriteE=0, ResultSrcE=0, PCSrcE=0, RdE=0, ALUResultE=0, PCTargetE=0.
- Register update priority, at each rising clk edge: rst > FlushE > StallE > load.
  - FlushE=1: all fields become 0 (bubble: no write, no memory access, no redirect, ALU op add).
  - FlushE=1 and StallE=1 together: flush wins.
  - StallE=1 alone: all fields hold.
  - Otherwise: load all D-stage inputs.
- Latency: D-stage inputs appear at E-stage outputs one cycle after capture. ALU, target and PCSrcE are combinational from the registered state plus the forward inputs.
- SrcA mux (ForwardAE): 00 → RD1E, 01 → ResultW, 10 → ALUResultM, 11 → RD1E (reserved).
- WriteDataE mux (ForwardBE): same mapping applied to RD2E.
- SrcB: ImmExtE when ALUSrcE=1, else WriteDataE.
- ALU codes:
  - 000 add.
  - 001 sub.
  - 010 and.
  - 011 or.
  - 100 xor.
  - 101 slt: signed two's-complement compare; result 1 or 0, zero-extended to XLEN.
  - 110 and 111: result 0.
- Arithmetic: add and sub wrap modulo 2^XLEN; no overflow flag.
- ZeroE = (ALUResultE == 0).
- PCSrcE = (BranchE & ZeroE) | JumpE.
- PCTargetE = PCE + ImmExtE, wrapping modulo 2^XLEN.
- Rs1E, Rs2E and RdE are registered copies, exported for load-use and forward detection.

Decomposition:
- Package ex_pkg holds:
  - ALU control localparams: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_XOR=3'b100, ALU_SLT=3'b101.
  - Forward-select localparams: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - A packed struct id_ex_t holding all ID/EX fields.
- One sub-module, alu(a, b, ALUControl, result, zero), purely combinational.
- Pipeline register and muxes live in ex_stage.

Test Plan:
- Reset mid-operation: rst asserted between clock edges while RegWriteE=1 → RegWriteE, PCSrcE and RdE read 0 before the next edge.
- Load and ALU ops: RD1D=7, RD2D=5, ALUSrcD=0, ALUControlD=001 → after one edge ALUResultE=2. With ALUControlD=101 and RD1D=0xFFFFFFFF → ALUResultE=1 (signed -1 < 5).
- Forwarding: ALUResultM=0x100, ResultW=0x200, ForwardAE=10, ForwardBE=01, ALUControl=000 → ALUResultE=0x300 and WriteDataE=0x200.
- Branch resolution: BranchD=1, RD1D=RD2D=9, sub, PCD=0x40, ImmExtD=0xFFFFFFF8 → PCSrcE=1, PCTargetE=0x38. With RD2D=8 → PCSrcE=0.
- Flush vs stall: E holds RegWriteE=1, RdE=3; assert FlushE=1 and StallE=1 for one edge → RegWriteE=0, RdE=0. Next cycle StallE=1 only, with new D inputs → fields stay 0.
- Stall hold and reserved code: StallE=1 for 3 edges with changing D inputs → E outputs unchanged. Then ALUControlD=110 → ALUResultE=0, ZeroE=1.
